// File: rtl/skeeball_pkg.sv
// Shared definitions for the skeeball lane controller: game states and hole point values.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package skeeball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Point values in units of 10
  localparam logic [3:0] PTS_100    = 4'd10;
  localparam logic [3:0] PTS_50     = 4'd5;
  localparam logic [3:0] PTS_40     = 4'd4;
  localparam logic [3:0] PTS_30     = 4'd3;
  localparam logic [3:0] PTS_20     = 4'd2;
  localparam logic [3:0] PTS_10     = 4'd1;
  localparam logic [3:0] PTS_GUTTER = 4'd0;

  // Highest set sensor wins when several holes report at once
  function automatic logic [3:0] hole_to_points(input logic [6:0] h);
    logic [3:0] p;
    p = PTS_GUTTER;
    if      (h[6]) p = PTS_100;
    else if (h[5]) p = PTS_50;
    else if (h[4]) p = PTS_40;
    else if (h[3]) p = PTS_30;
    else if (h[2]) p = PTS_20;
    else if (h[1]) p = PTS_10;
    return p;
  endfunction

endpackage

// File: rtl/skeeball_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, one-hot grant.
// Latency: grant is combinational from req; pointer moves past the winner at the next edge.
// Backpressure: en=0 suppresses all grants; clr returns the pointer to lane 0.
module skeeball_rr_arbiter #(
  parameter int NUM_LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  output logic [NUM_LANES-1:0] gnt
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] sel;
  logic             found;
  int               idx;

  // Scan lanes starting at the pointer, wrapping, and take the first request
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      sel = idx[PTR_W-1:0];
      if (en && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
        gidx     = sel;
      end
    end
  end

  // Pointer lands just after the lane that was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= '0;
    else if (clr)    ptr_q <= '0;
    else if (found)  ptr_q <= (int'(gidx) == NUM_LANES - 1) ? '0 : gidx + PTR_W'(1);
  end

endmodule

// File: rtl/skeeball_lane_ctrl.sv
// Multi-lane skeeball controller: sensor sync, ball-event detect, shared adder, game FSM.
// Latency: raw rise sampled at edge k -> pending at k+2 -> score/balls at k+3 when uncontended.
// Backpressure: one pending event per lane; a further event while pending is dropped. SKEEBALL_HIGH_SCORE_EN adds high-score tracking.
module skeeball_lane_ctrl
  import skeeball_pkg::*;
#(
  parameter int NUM_LANES      = 2,
  parameter int BALLS_PER_GAME = 9,
  parameter int SCORE_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7*NUM_LANES-1:0]       hole,
  output logic [SCORE_W*NUM_LANES-1:0] score,
  output logic [4*NUM_LANES-1:0]       balls,
  output logic [1:0]                   state,
  output logic [NUM_LANES-1:0]         grant,
  output logic                         drop,
  output logic [SCORE_W-1:0]           high_score,
  output logic                         new_high
);

  logic [7*NUM_LANES-1:0] sync1_q, sync2_q;
  logic [NUM_LANES-1:0]   prev_or_q, lane_or, evt, accept, set_pend, drop_vec, pend_q;
  logic [3:0]             val_q   [NUM_LANES];
  logic [3:0]             balls_q [NUM_LANES];
  logic [SCORE_W-1:0]     score_q [NUM_LANES];
  logic [SCORE_W-1:0]     sat_sum [NUM_LANES];
  logic [SCORE_W:0]       raw_sum [NUM_LANES];
  logic                   drop_q, in_play, all_done;
  state_e                 state_q, state_d;

  // Two-flop synchronizer plus last-cycle OR per lane for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_or_q <= '0;
    end else begin
      sync1_q   <= hole;
      sync2_q   <= sync1_q;
      prev_or_q <= lane_or;
    end
  end

  // Event qualification; a granted lane can re-arm only if a ball remains after this update
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_or[l]  = |sync2_q[7*l +: 7];
      evt[l]      = lane_or[l] & ~prev_or_q[l];
      accept[l]   = evt[l] && in_play && !start &&
                    (grant[l] ? (balls_q[l] > 4'd1) : (balls_q[l] != 4'd0));
      set_pend[l] = accept[l] & (~pend_q[l] | grant[l]);
      drop_vec[l] = accept[l] & pend_q[l] & ~grant[l];
      raw_sum[l]  = {1'b0, score_q[l]} + {{(SCORE_W-3){1'b0}}, val_q[l]};
      sat_sum[l]  = raw_sum[l][SCORE_W] ? '1 : raw_sum[l][SCORE_W-1:0];
    end
  end

  skeeball_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (~start),
    .req   (pend_q),
    .gnt   (grant)
  );

  // Per-lane score, ball count and pending event; start reloads every lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        score_q[l] <= '0;
        balls_q[l] <= '0;
        val_q[l]   <= '0;
      end
    end else if (start) begin
      pend_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        score_q[l] <= '0;
        balls_q[l] <= 4'(BALLS_PER_GAME);
        val_q[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (grant[l]) begin
          score_q[l] <= sat_sum[l];
          balls_q[l] <= balls_q[l] - 4'd1;
          pend_q[l]  <= 1'b0;
        end
        if (set_pend[l]) begin
          pend_q[l] <= 1'b1;
          val_q[l]  <= hole_to_points(sync2_q[7*l +: 7]);
        end
      end
    end
  end

  // Drop indication, registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= |drop_vec;
  end

  // Game over once no lane has balls left or work outstanding
  always_comb begin
    all_done = (pend_q == '0);
    for (int l = 0; l < NUM_LANES; l++)
      if (balls_q[l] != 4'd0) all_done = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; start wins from any state
  always_comb begin
    state_d = state_q;
    if (start) state_d = ST_PLAY;
    else begin
      case (state_q)
        ST_PLAY: if (all_done) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs and packed output buses
  always_comb begin
    state   = state_q;
    in_play = (state_q == ST_PLAY);
    drop    = drop_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      score[SCORE_W*l +: SCORE_W] = score_q[l];
      balls[4*l +: 4]             = balls_q[l];
    end
  end

`ifdef SKEEBALL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best_now, hs_q;
  logic               nh_q;

  // Best lane score at this moment
  always_comb begin
    best_now = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (score_q[l] > best_now) best_now = score_q[l];
  end

  // Record a new best at the end of a game; survives start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= '0;
      nh_q <= 1'b0;
    end else begin
      nh_q <= 1'b0;
      if (state_q == ST_PLAY && state_d == ST_DONE && best_now > hs_q) begin
        hs_q <= best_now;
        nh_q <= 1'b1;
      end
    end
  end

  assign high_score = hs_q;
  assign new_high   = nh_q;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule

// File: tb/tb_skeeball_lane_ctrl.sv
// Bench for skeeball_lane_ctrl: directed game scenarios followed by random sensor traffic.
// Latency: outputs compared to a cycle model on every falling edge.
// Backpressure: drops arise from three lanes competing for the shared adder.
module tb_skeeball_lane_ctrl;
  localparam int N    = 3;
  localparam int BPG  = 9;
  localparam int SW   = 6;
  localparam int MAXS = (1 << SW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [7*N-1:0]   hole = '0;
  logic [SW*N-1:0]  score;
  logic [4*N-1:0]   balls;
  logic [1:0]       state;
  logic [N-1:0]     grant;
  logic             drop;
  logic [SW-1:0]    high_score;
  logic             new_high;

  skeeball_lane_ctrl #(.NUM_LANES(N), .BALLS_PER_GAME(BPG), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hole(hole), .score(score), .balls(balls),
    .state(state), .grant(grant), .drop(drop), .high_score(high_score), .new_high(new_high)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_score [N];
  int         m_balls [N];
  bit         m_pend  [N];
  int         m_val   [N];
  logic [6:0] r1 [N], r2 [N], r3 [N];   // raw samples from 1, 2, 3 edges ago
  int         m_ptr, m_state, m_hs;
  bit         m_drop, m_nh;

  function automatic int points(input logic [6:0] h);
    if (h[6]) return 10;
    if (h[5]) return 5;
    if (h[4]) return 4;
    if (h[3]) return 3;
    if (h[2]) return 2;
    if (h[1]) return 1;
    return 0;
  endfunction

  function automatic int grant_idx();
    if (start) return -1;
    for (int i = 0; i < N; i++)
      if (m_pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < N; l++) begin
        m_score[l] = 0; m_balls[l] = 0; m_pend[l] = 0; m_val[l] = 0;
        r1[l] = '0; r2[l] = '0; r3[l] = '0;
      end
      m_ptr = 0; m_state = 0; m_hs = 0; m_drop = 0; m_nh = 0;
    end else begin
      int  g, best;
      bit  done, ev, cap, old_p;
      g = grant_idx();
      done = 1;
      best = 0;
      for (int l = 0; l < N; l++) begin
        if (m_balls[l] != 0 || m_pend[l]) done = 0;
        if (m_score[l] > best) best = m_score[l];
      end
      m_drop = 0;
      m_nh   = 0;
      if (start) begin
        for (int l = 0; l < N; l++) begin
          m_score[l] = 0; m_balls[l] = BPG; m_pend[l] = 0; m_val[l] = 0;
        end
        m_ptr = 0; m_state = 1;
      end else begin
        for (int l = 0; l < N; l++) begin
          ev    = (r2[l] != 0) && (r3[l] == 0);
          old_p = m_pend[l];
          cap   = ev && m_state == 1 && ((l == g) ? m_balls[l] > 1 : m_balls[l] > 0);
          if (l == g) begin
            m_score[l] = (m_score[l] + m_val[l] > MAXS) ? MAXS : m_score[l] + m_val[l];
            m_balls[l] = m_balls[l] - 1;
            m_pend[l]  = 0;
          end
          if (cap) begin
            if (old_p && l != g) m_drop = 1;
            else begin
              m_pend[l] = 1;
              m_val[l]  = points(r2[l]);
            end
          end
        end
        if (g >= 0) m_ptr = (g + 1) % N;
        if (m_state == 1 && done) begin
          m_state = 2;
`ifdef SKEEBALL_HIGH_SCORE_EN
          if (best > m_hs) begin
            m_hs = best;
            m_nh = 1;
          end
`endif
        end
      end
      for (int l = 0; l < N; l++) begin
        r3[l] = r2[l];
        r2[l] = r1[l];
        r1[l] = hole[7*l +: 7];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [SW*N-1:0] es;
  logic [4*N-1:0]  eb;
  logic [N-1:0]    eg;
  always @(negedge clk) begin
    if (cmp_en) begin
      int g;
      g  = grant_idx();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int l = 0; l < N; l++) begin
        es[SW*l +: SW] = SW'(m_score[l]);
        eb[4*l +: 4]   = 4'(m_balls[l]);
      end
      chk("state", 32'(state), 32'(m_state));
      chk("score", 32'(score), 32'(es));
      chk("balls", 32'(balls), 32'(eb));
      chk("grant", 32'(grant), 32'(eg));
      chk("drop", 32'(drop), 32'(m_drop));
      chk("high_score", 32'(high_score), 32'(m_hs));
      chk("new_high", 32'(new_high), 32'(m_nh));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lane(input int l, input logic [6:0] v);
    hole[7*l +: 7] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic round(input logic [6:0] v0, input logic [6:0] v1, input logic [6:0] v2);
    set_lane(0, v0); set_lane(1, v1); set_lane(2, v2);
    step(1);
    hole = '0;
    step(6);
  endtask

  task automatic hit0(input logic [6:0] v);
    round(v, 7'd0, 7'd0);
  endtask

  localparam logic [6:0] G = 7'b0000001;

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_score", 32'(score), 32'd0);
    chk("reset_balls", 32'(balls), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);

    // First ball: 20 points on lane 0
    pulse_start();
    chk("start_state", 32'(state), 32'd1);
    chk("start_balls0", 32'(balls[3:0]), 32'd9);
    set_lane(0, 7'b0000100);
    step(3);
    chk("d1_grant", 32'(grant), 32'd1);
    step(1);
    chk("d1_score0", 32'(score[SW-1:0]), 32'd2);
    chk("d1_balls0", 32'(balls[3:0]), 32'd8);
    hole = '0;
    step(4);

    // Simultaneous lanes 0 and 1, pointer at 0
    pulse_start();
    step(3);
    set_lane(0, 7'b0100000); set_lane(1, 7'b1000000);
    step(3);
    chk("d2_grant_a", 32'(grant), 32'd1);
    step(1);
    chk("d2_grant_b", 32'(grant), 32'd2);
    chk("d2_score0", 32'(score[SW-1:0]), 32'd5);
    step(1);
    chk("d2_score1", 32'(score[SW +: SW]), 32'd10);
    hole = '0;
    step(4);

    // Two bits set: only the higher one counts
    set_lane(0, 7'b1000100);
    step(4);
    chk("d3_score0", 32'(score[SW-1:0]), 32'd15);
    hole = '0;
    step(4);

    // Lane 0 re-triggers while lanes 1 and 2 occupy the adder
    set_lane(0, 7'b0001000); set_lane(1, 7'b0000010); set_lane(2, 7'b0000010);
    step(1);
    set_lane(0, 7'd0);
    step(1);
    set_lane(0, 7'b0001000);
    step(1);
    hole = '0;
    step(2);
    chk("d4_drop", 32'(drop), 32'd1);
    step(3);
    chk("d4_score0", 32'(score[SW-1:0]), 32'd18);
    chk("d4_balls0", 32'(balls[3:0]), 32'd6);

    // Restart mid-game
    pulse_start();
    hit0(7'b0100000); hit0(7'b0000100); hit0(G); hit0(G); hit0(G);
    chk("mid_score0", 32'(score[SW-1:0]), 32'd7);
    chk("mid_balls0", 32'(balls[3:0]), 32'd4);
    pulse_start();
    chk("restart_score0", 32'(score[SW-1:0]), 32'd0);
    chk("restart_balls0", 32'(balls[3:0]), 32'd9);
    chk("restart_state", 32'(state), 32'd1);

    // Full game, best lane 30 points
    round(7'b0001000, G, G);
    repeat (8) round(G, G, G);
    chk("gameA_state", 32'(state), 32'd2);
`ifdef SKEEBALL_HIGH_SCORE_EN
    chk("gameA_high", 32'(high_score), 32'd3);
`endif

    // Full game, best lane 20 points: high score holds
    pulse_start();
    round(7'b0000100, G, G);
    repeat (8) round(G, G, G);
    chk("gameB_state", 32'(state), 32'd2);
`ifdef SKEEBALL_HIGH_SCORE_EN
    chk("gameB_high", 32'(high_score), 32'd3);
`endif

    // Nine 100-point balls per lane saturate the score
    pulse_start();
    repeat (9) round(7'b1000000, 7'b1000000, 7'b1000000);
    chk("sat_score0", 32'(score[SW-1:0]), 32'(MAXS));
    chk("sat_state", 32'(state), 32'd2);
    round(7'b1000000, 7'b1000000, 7'b1000000);
    chk("extra_balls", 32'(balls), 32'd0);
    chk("extra_score0", 32'(score[SW-1:0]), 32'(MAXS));

    // Random traffic with occasional (sometimes held) start
    pulse_start();
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 2) == 0) set_lane(l, 7'($urandom_range(0, 127)));
      if (start) start = ($urandom_range(0, 1) == 0);
      else       start = ($urandom_range(0, 249) == 0);
      step(1);
    end
    start = 1'b0;
    hole = '0;
    step(4);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/skeeball_lane_ctrl.md
Name: skeeball_lane_ctrl

Overview:
Multi-lane skeeball game controller. Synchronizes each lane's hole sensors and detects new ball events. A round-robin arbiter shares a single point-adder between the lanes. Tracks each lane's score and balls remaining, and sequences the game IDLE -> PLAY -> DONE. Sits between the raw hole-sensor inputs and the score/ball displays.

Parameters:
NUM_LANES, 2, number of player lanes sharing the adder (1..8)
BALLS_PER_GAME, 9, balls loaded per lane on start (1..15)
SCORE_W, 8, per-lane score width; units of 10 points

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous level/pulse; starts a new game on all lanes
hole  in  7*NUM_LANES  raw sensors, lane L at [7L+6:7L]; bit6=100, bit5=50, bit4=40, bit3=30, bit2=20, bit1=10, bit0=0 (gutter)
score  out  SCORE_W*NUM_LANES  per-lane score, lane L at [SCORE_W*L+:SCORE_W]
balls  out  4*NUM_LANES  per-lane balls remaining (binary)
state  out  2  00 IDLE, 01 PLAY, 10 DONE
grant  out  NUM_LANES  one-hot lane served by the adder this cycle (0 if none)
drop  out  1  one-cycle pulse: an event was discarded because the lane was already pending
high_score  out  SCORE_W  best score seen (feature only; 0 otherwise)
new_high  out  1  one-cycle pulse on high-score update (feature only; 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all scores=0, balls=0, pending=0; RR pointer=lane 0; grant=0, drop=0; high_score=0.
- Sync: hole passes through a 2-flop synchronizer. A lane event is a rising edge of the OR of the lane's 7 synced bits.
- On an event, value = highest set synced bit, priority-encoded: 100->10, 50->5, 40->4, 30->3, 20->2, 10->1, 0->0. Value and the pending flag are registered.
- Events are accepted only in PLAY with that lane's balls>0. Otherwise they are ignored silently.
- An event on a lane whose pending flag is set: discarded, drop pulses.
- Arbiter: among pending lanes, grant the first at or after the RR pointer. Grant is combinational from pending. On grant, RR pointer = granted lane+1, wrapping.
- Granted lane at the next edge: score += value, saturating at 2^SCORE_W-1; balls -= 1; pending cleared.
- A new event on the granted lane in the same cycle re-sets pending (no drop).
- Latency, uncontended: raw rise sampled at edge k -> pending set at edge k+2 -> score/balls updated at edge k+3.
- Contention: one update per cycle. N simultaneous lanes finish within N cycles, in RR order.
- FSM:
  - IDLE -> PLAY on start.
  - PLAY -> DONE when every lane has balls=0 and pending=0.
  - DONE -> PLAY on start.
- start in any state, including mid-PLAY: scores=0, balls=BALLS_PER_GAME, pending=0, RR pointer=0, state=PLAY. start overrides any grant in the same cycle.
- start held high keeps the block in reset-to-play. Events are accepted only after start falls.
- Gutter (value 0) still consumes a ball.

Optional Feature:
SKEEBALL_HIGH_SCORE_EN
- Defined: on each PLAY->DONE transition, compare the max lane score against high_score. If greater, load it and pulse new_high for one cycle. high_score survives start and is cleared only by rst_n.
- Undefined: ports remain; high_score=0, new_high=0 constant.

Decomposition:
- Package skeeball_pkg: state encoding constants (IDLE/PLAY/DONE), point-value constants, function hole_to_points(7-bit) -> 4-bit value.
- Sub-module skeeball_rr_arbiter: NUM_LANES request in, one-hot grant out, internal pointer, async active-low reset.

Test Plan:
- Reset then start, NUM_LANES=2; lane0 hole=7'b0000100 (20) -> 3 edges after sampling: score0=2, balls0=8, grant=01 for 1 cycle.
- Lane0 and lane1 rise in the same cycle (50 and 100), pointer=0 -> grant 01 then 10 on consecutive cycles; score0=5, score1=10.
- Lane0 hole=7'b1000100 (two bits set) -> score0 += 10 only.
- Two lane0 rises 1 cycle apart while lane1 holds the adder -> drop pulses once; score0 reflects one event.
- Nine 100-point balls per lane, SCORE_W=6 -> score saturates at 63; after the last ball state=DONE. A 10th hit is ignored, balls stay 0.
- start mid-game (score0=7, balls0=4) -> next cycle scores=0, balls=9, state=PLAY. With the feature on, finishing at 30 then a game at 20 -> high_score=30, new_high pulses once.
